alu_result_capture: RTL and testbench

//  Upstream stage of the per-digit hex seven-segment decoders in the ALU board top.

---
 rtl/alu_pkg.sv | 15 +
 rtl/key_debounce.sv | 78 +++++++
 rtl/alu_result_capture.sv | 84 ++++++++
 tb/tb_alu_result_capture.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result capture path.
package alu_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} cap_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic int digits_for(input int n);
        return (n + 3) / 4;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces an active-low pushbutton; press_pulse marks the
// edge on which a press is confirmed (PRESS_CHK -> HELD).
module key_debounce
    import alu_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    cap_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          k;

    assign k = ~sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], key_n};
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (k) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!k) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    // Decoded, not registered, so capture lands on this same edge.
                    state_d     = HELD;
                    press_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!k) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (k) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_result_capture.sv
// Snapshots ALU result and flags on each debounced key press and holds them
// as per-digit nibbles for the hex display decoders.
module alu_result_capture
    import alu_pkg::*;
#(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 8,
    parameter int DIGITS     = (N + 3) / 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          result,
    input  logic [3:0]            flags,
    input  logic                  key_n,
    output logic [4*DIGITS-1:0]   hex_nibble,
    output logic [DIGITS-1:0]     blank,
    output logic [3:0]            flags_q,
    output logic                  valid,
    output logic                  cap_pulse,
    output logic [CNT_W-1:0]      cap_count
);

    logic press;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .press_pulse(press)
    );

    logic [4*DIGITS-1:0] hex_q, hex_d;
    logic [3:0]          flag_cap_q, flag_cap_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                valid_q, valid_d;
    logic                pulse_q, pulse_d;
    logic [CNT_W-1:0]    count_q, count_d;

    always_comb begin
        hex_d      = hex_q;
        flag_cap_d = flag_cap_q;
        blank_d    = blank_q;
        valid_d    = valid_q;
        pulse_d    = 1'b0;
        count_d    = count_q;
        if (press) begin
            // Zero-extend so unused bits of the top digit read as 0.
            hex_d          = '0;
            hex_d[N-1:0]   = result;
            flag_cap_d     = flags;
            blank_d        = '0;
            valid_d        = 1'b1;
            pulse_d        = 1'b1;
            count_d        = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex_q      <= '0;
            flag_cap_q <= '0;
            blank_q    <= '1;
            valid_q    <= 1'b0;
            pulse_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            hex_q      <= hex_d;
            flag_cap_q <= flag_cap_d;
            blank_q    <= blank_d;
            valid_q    <= valid_d;
            pulse_q    <= pulse_d;
            count_q    <= count_d;
        end
    end

    assign hex_nibble = hex_q;
    assign flags_q    = flag_cap_q;
    assign blank      = blank_q;
    assign valid      = valid_q;
    assign cap_pulse  = pulse_q;
    assign cap_count  = count_q;

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed/randomized bench for alu_result_capture with a run-length debounce model.
module tb_alu_result_capture;
    import alu_pkg::*;

    localparam int N   = 8;
    localparam int DEB = 4;
    localparam int CW  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic [7:0] result = '0;
    logic [3:0] flags = '0;
    logic [7:0] hex_nibble;
    logic [1:0] blank;
    logic [3:0] flags_q;
    logic       valid;
    logic       cap_pulse;
    logic [3:0] cap_count;

    alu_result_capture #(.N(N), .DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .result    (result),
        .flags     (flags),
        .key_n     (key_n),
        .hex_nibble(hex_nibble),
        .blank     (blank),
        .flags_q   (flags_q),
        .valid     (valid),
        .cap_pulse (cap_pulse),
        .cap_count (cap_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, n_pulses = 0, cyc = 0, last_pulse = -1, start = 0;
    bit rand_res = 1'b0;

    // Reference: a level change is accepted once the synchronized key has
    // disagreed with the debounced level for DEB+1 consecutive edges.
    bit         m_s1 = 1'b1, m_s2 = 1'b1, m_level = 1'b0, m_valid = 1'b0, m_pulse = 1'b0;
    int         m_run = 0, m_count = 0;
    logic [7:0] m_hex = '0;
    logic [3:0] m_flags = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic kn);
        bit k;
        key_n = kn;
        if (rand_res) begin
            result = 8'($urandom);
            flags  = 4'($urandom);
        end
        if (!rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_run = 0;
            m_hex = '0; m_flags = '0; m_valid = 1'b0; m_pulse = 1'b0; m_count = 0;
        end else begin
            k = ~m_s2;
            m_pulse = 1'b0;
            m_run = (k != m_level) ? m_run + 1 : 0;
            if (m_run == DEB + 1) begin
                m_level = k;
                m_run   = 0;
                if (k) begin
                    m_hex = result; m_flags = flags; m_valid = 1'b1; m_pulse = 1'b1;
                    m_count = (m_count + 1) % 16;
                end
            end
            m_s2 = m_s1;
            m_s1 = kn;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cap_pulse) begin
            n_pulses++;
            last_pulse = cyc;
        end
        chk("cap_pulse", 16'(cap_pulse), 16'(m_pulse));
        chk("hex_nibble", 16'(hex_nibble), 16'(m_hex));
        chk("flags_q", 16'(flags_q), 16'(m_flags));
        chk("valid", 16'(valid), 16'(m_valid));
        chk("blank", 16'(blank), 16'({2{~m_valid}}));
        chk("cap_count", 16'(cap_count), 16'(m_count));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hex"}, 16'(hex_nibble), 16'h00);
        chk({tag, "_blank"}, 16'(blank), 16'h3);
        chk({tag, "_valid"}, 16'(valid), 16'h0);
        chk({tag, "_count"}, 16'(cap_count), 16'h0);
        chk({tag, "_flags"}, 16'(flags_q), 16'h0);
    endtask

    initial begin
        // 1. reset
        rst_n = 1'b0;
        repeat (3) step(1'b1);
        rst_n = 1'b1;
        step(1'b1);
        chk_reset_vals("reset");

        // 2. clean press, latency and captured value
        result = 8'hA5; flags = 4'b1000; n_pulses = 0; start = cyc;
        repeat (20) step(1'b0);
        chk("t2_latency", 16'(last_pulse - start - 1), 16'(DEB + 2));
        chk("t2_pulses", 16'(n_pulses), 16'd1);
        chk("t2_hex", 16'(hex_nibble), 16'h00A5);
        chk("t2_flagN", 16'(flags_q[FLAG_N]), 16'd1);
        chk("t2_blank", 16'(blank), 16'd0);
        chk("t2_count", 16'(cap_count), 16'd1);
        repeat (10) step(1'b1);

        // 3. bounce then a clean press from IDLE
        n_pulses = 0;
        step(1'b0); step(1'b0); step(1'b1); step(1'b0); step(1'b0);
        repeat (10) step(1'b1);
        chk("t3_bounce_pulses", 16'(n_pulses), 16'd0);
        start = cyc;
        repeat (10) step(1'b0);
        chk("t3_latency", 16'(last_pulse - start - 1), 16'(DEB + 2));
        repeat (10) step(1'b1);

        // 4. long hold with result changing
        n_pulses = 0; result = 8'h11;
        for (int i = 0; i < 100; i++) begin
            if (i == 4) result = 8'h22;
            if (i == 40) result = 8'h33;
            step(1'b0);
        end
        chk("t4_pulses", 16'(n_pulses), 16'd1);
        chk("t4_hex", 16'(hex_nibble), 16'h0022);
        repeat (10) step(1'b1);

        // 5. 17 presses with random data, one release bounce
        rst_n = 1'b0; step(1'b1); step(1'b1); rst_n = 1'b1;
        rand_res = 1'b1; n_pulses = 0;
        for (int p = 0; p < 17; p++) begin
            repeat (DEB + 3 + $urandom_range(0, 5)) step(1'b0);
            if (p == 8) begin
                step(1'b1); step(1'b1); step(1'b0);
            end
            repeat (DEB + 4 + $urandom_range(0, 5)) step(1'b1);
        end
        chk("t5_pulses", 16'(n_pulses), 16'd17);
        chk("t5_count", 16'(cap_count), 16'd1);
        rand_res = 1'b0;

        // 6. reset during PRESS_CHK, then during HELD
        n_pulses = 0; result = 8'h5A;
        repeat (4) step(1'b0);
        rst_n = 1'b0; step(1'b1); rst_n = 1'b1;
        chk_reset_vals("t6_presschk");
        repeat (10) step(1'b1);
        chk("t6_presschk_pulses", 16'(n_pulses), 16'd0);
        repeat (8) step(1'b0);
        rst_n = 1'b0; step(1'b1); rst_n = 1'b1;
        chk_reset_vals("t6_held");
        repeat (10) step(1'b1);
        chk("t6_held_pulses", 16'(n_pulses), 16'd1);
        chk_reset_vals("t6_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
